// File: rtl/sram_sp_arb_pkg.sv
// Shared types and defaults for the two-port single-port-SRAM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_sp_arb_pkg;

    localparam int NUM_PORTS = 2;

    // Defaults sized for the 256x8 macro.
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 8;
    localparam int DEPTH_DEF = 256;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

endpackage

// File: rtl/sram_sp_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with an internal priority pointer.
// Latency: grant is combinational from valid; pointer updates at the clock edge.
// Backpressure: no grant while enable is low; the pointer holds without a grant.
//
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   valid[1:0]      request per input
//   enable          gates all grants (low during init / reset recovery)
//   grant[1:0]      one-hot grant, all zero when nothing is granted
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // 0: port 0 has priority on contention, 1: port 1 has priority.
    logic ptr_q;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After any grant, priority passes to the port that was not granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else if (|grant) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM macro (256x8, active-low CE/WE) between two requesters.
// Latency: accepted access drives the macro in the same cycle; read data returns 1 cycle later.
// Backpressure: req_ready is the round-robin grant; responses have no backpressure.
//
// Optional feature macro: SRAM_SP_ARB_INIT_EN -- when defined, a post-reset sweep
// writes zero to every word before any request is served (init_done low until then).
//
// Ports:
//   clock, reset_n                     clock (also the macro CLK), async active-low reset
//   req_valid/req_ready/req_write      per-port handshake and direction (bit i = port i)
//   req_addr/req_wdata                 per-port address/data, port i at [i*W +: W]
//   resp_valid/resp_rdata              per-port read-return pulse, shared read data
//   init_done                          high once requests are being served
//   sram_ceb/sram_web/sram_a/sram_d    macro pins (active-low CE/WE)
//   sram_q                             macro registered read data
module sram_sp_arbiter
    import sram_sp_arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_PORTS-1:0]      req_valid,
    output logic [NUM_PORTS-1:0]      req_ready,
    input  logic [NUM_PORTS-1:0]      req_write,
    input  logic [NUM_PORTS*AW-1:0]   req_addr,
    input  logic [NUM_PORTS*DW-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]      resp_valid,
    output logic [DW-1:0]             resp_rdata,
    output logic                      init_done,
    output logic                      sram_ceb,
    output logic                      sram_web,
    output logic [AW-1:0]             sram_a,
    output logic [DW-1:0]             sram_d,
    input  logic [DW-1:0]             sram_q
);

    // The sweep and address hold logic assume the macro is fully addressed.
    if (DEPTH != (2 ** AW)) begin : g_bad_depth
        $error("sram_sp_arbiter: DEPTH must equal 2**AW");
    end

    state_e                state_q;
    logic                  live_q;     // low during reset so nothing is granted then
    logic                  ceb_q;      // sweep-phase pin registers
    logic                  web_q;
    logic [AW-1:0]         a_q;        // sweep counter / last address driven
    logic [DW-1:0]         d_q;        // last write data driven
    logic [NUM_PORTS-1:0]  rd_q;       // read issued last cycle, per port

    logic [NUM_PORTS-1:0]  gnt;
    logic                  gnt_any;
    logic                  sel;
    logic                  g_write;
    logic [AW-1:0]         g_addr;
    logic [DW-1:0]         g_wdata;
    logic                  serve_en;

    assign serve_en = (state_q == ST_SERVE) && live_q;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   (req_valid),
        .enable  (serve_en),
        .grant   (gnt)
    );

    assign gnt_any = |gnt;
    assign sel     = gnt[1];
    assign g_write = sel ? req_write[1]          : req_write[0];
    assign g_addr  = sel ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
    assign g_wdata = sel ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];

    assign req_ready  = gnt;
    assign resp_valid = rd_q;
    // Macro Q is only meaningful the cycle after a read; force zero otherwise.
    assign resp_rdata = (|rd_q) ? sram_q : '0;

    // Macro pins: registered during the sweep, combinational from the grant when
    // serving. Without a grant the address/data hold their last driven values.
    always_comb begin
        sram_ceb = ceb_q;
        sram_web = web_q;
        sram_a   = a_q;
        sram_d   = d_q;
        if (state_q == ST_SERVE) begin
            sram_ceb = ~gnt_any;
            sram_web = 1'b1;
            if (gnt_any) begin
                sram_web = ~g_write;
                sram_a   = g_addr;
                sram_d   = g_wdata;
            end
        end
    end

`ifdef SRAM_SP_ARB_INIT_EN
    logic done_q;
    assign init_done = done_q;
`else
    assign init_done = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
`ifdef SRAM_SP_ARB_INIT_EN
            state_q <= ST_INIT;
            done_q  <= 1'b0;
`else
            state_q <= ST_SERVE;
`endif
            live_q  <= 1'b0;
            ceb_q   <= 1'b1;
            web_q   <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
            rd_q    <= '0;
        end else begin
            live_q <= 1'b1;
            rd_q   <= gnt & ~req_write;
            case (state_q)
`ifdef SRAM_SP_ARB_INIT_EN
                ST_INIT: begin
                    // First edge after reset arms the sweep at address 0; the
                    // switch to SERVE happens once address DEPTH-1 has been driven.
                    if (ceb_q) begin
                        ceb_q <= 1'b0;
                        web_q <= 1'b0;
                        a_q   <= '0;
                        d_q   <= '0;
                    end else if (a_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_SERVE;
                        done_q  <= 1'b1;
                        ceb_q   <= 1'b1;
                        web_q   <= 1'b1;
                    end else begin
                        a_q <= a_q + 1'b1;
                    end
                end
`endif
                ST_SERVE: begin
                    if (gnt_any) begin
                        a_q <= g_addr;
                        d_q <= g_wdata;
                    end
                end
                default: begin
                    state_q <= ST_SERVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed self-checking bench for sram_sp_arbiter with a behavioural 256x8 macro.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sram_sp_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [7:0]  resp_rdata;
    logic        init_done;
    logic        sram_ceb;
    logic        sram_web;
    logic [7:0]  sram_a;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q;

    logic [7:0]  mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sram_sp_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_ceb   (sram_ceb),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    // Single-port macro: write at the edge, registered Q after a read.
    always @(posedge clock) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] w,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic [7:0] a1, input logic [7:0] d1);
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        sram_q  = 8'h00;
        reset_n = 1'b0;
        drv(2'b01, 2'b00, 8'h7F, 8'h00, 8'h00, 8'h00);

        // Reset state, with a request pending that must not be accepted.
        cyc(); #3;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_resp",  resp_valid, 2'b00);
        chk("rst_rdata", resp_rdata, 8'h00);
        chk("rst_ceb",   sram_ceb, 1'b1);
        chk("rst_web",   sram_web, 1'b1);
        chk("rst_a",     sram_a, 8'h00);
        chk("rst_d",     sram_d, 8'h00);
`ifdef SRAM_SP_ARB_INIT_EN
        chk("rst_done",  init_done, 1'b0);
`else
        chk("rst_done",  init_done, 1'b1);
`endif
        reset_n = 1'b1;

`ifdef SRAM_SP_ARB_INIT_EN
        // Sweep: 256 write cycles of zero, address counting up, no grants.
        for (int i = 0; i < 256; i++) begin
            cyc(); #3;
            chk("init_a", sram_a, i);
            chk("init_pins", {sram_ceb, sram_web, sram_d, req_ready, init_done}, 12'h000);
        end
        cyc(); #3;
        chk("init_done", init_done, 1'b1);
        chk("init_rdy",  req_ready, 2'b01);
        cyc(); drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); #3;
        chk("init_rd_vld", resp_valid, 2'b01);
        chk("init_rd_dat", resp_rdata, 8'h00);
`else
        // No sweep: serving starts right away; write 0 then read it back.
        cyc(); drv(2'b01, 2'b01, 8'h7F, 8'h00, 8'h00, 8'h00); #3;
        chk("noinit_done", init_done, 1'b1);
        chk("noinit_rdy",  req_ready, 2'b01);
        cyc(); drv(2'b01, 2'b00, 8'h7F, 8'h00, 8'h00, 8'h00); #3;
        chk("noinit_rd_rdy", req_ready, 2'b01);
        cyc(); drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); #3;
        chk("noinit_rd_vld", resp_valid, 2'b01);
        chk("noinit_rd_dat", resp_rdata, 8'h00);
`endif

        // Single-port write then read of the same address.
        cyc(); drv(2'b01, 2'b01, 8'h10, 8'hA5, 8'h00, 8'h00); #3;
        chk("wr_ready", req_ready, 2'b01);
        chk("wr_pins",  {sram_ceb, sram_web}, 2'b00);
        chk("wr_a",     sram_a, 8'h10);
        chk("wr_d",     sram_d, 8'hA5);
        cyc(); drv(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00); #3;
        chk("rd_ready", req_ready, 2'b01);
        chk("rd_pins",  {sram_ceb, sram_web}, 2'b01);
        chk("wr_noresp", resp_valid, 2'b00);
        cyc(); drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); #3;
        chk("rd_vld",   resp_valid, 2'b01);
        chk("rd_dat",   resp_rdata, 8'hA5);
        chk("idle_ceb", sram_ceb, 1'b1);
        chk("hold_a",   sram_a, 8'h10);

        // Seed 0x01/0x02 from port 1 (pointer ends at port 0).
        cyc(); drv(2'b10, 2'b10, 8'h00, 8'h00, 8'h01, 8'h11); #3;
        chk("seed1_rdy", req_ready, 2'b10);
        cyc(); drv(2'b10, 2'b10, 8'h00, 8'h00, 8'h02, 8'h22); #3;
        chk("seed2_rdy", req_ready, 2'b10);

        // Contention: grants 0,1,0,1 with responses lagging one cycle.
        for (int k = 0; k < 4; k++) begin
            cyc(); drv(2'b11, 2'b00, 8'h01, 8'h00, 8'h02, 8'h00); #3;
            chk("rr_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            if (k == 0) begin
                chk("rr_resp", resp_valid, 2'b00);
            end else if (k % 2 == 1) begin
                chk("rr_resp", resp_valid, 2'b01);
                chk("rr_dat",  resp_rdata, 8'h11);
            end else begin
                chk("rr_resp", resp_valid, 2'b10);
                chk("rr_dat",  resp_rdata, 8'h22);
            end
        end
        cyc(); drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); #3;
        chk("rr_last_resp", resp_valid, 2'b10);
        chk("rr_last_dat",  resp_rdata, 8'h22);

        // Port 1 writes 0xFF, port 0 reads it back the next cycle.
        cyc(); drv(2'b10, 2'b10, 8'h00, 8'h00, 8'hFF, 8'h3C); #3;
        chk("mix_wr_rdy", req_ready, 2'b10);
        chk("mix_wr_ceb", sram_ceb, 1'b0);
        cyc(); drv(2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00); #3;
        chk("mix_rd_rdy", req_ready, 2'b01);
        chk("mix_rd_ceb", sram_ceb, 1'b0);
        cyc(); drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); #3;
        chk("mix_vld", resp_valid, 2'b01);
        chk("mix_dat", resp_rdata, 8'h3C);

        // Idle: macro deselected, no responses.
        for (int k = 0; k < 10; k++) begin
            cyc(); #3;
            chk("idle", {sram_ceb, resp_valid}, 3'b100);
        end

        // Pointer held at port 1 (last grant went to port 0).
        cyc(); drv(2'b11, 2'b00, 8'h01, 8'h00, 8'h02, 8'h00); #3;
        chk("ptr_hold", req_ready, 2'b10);

        // Reset in the cycle after the read grant: the response is dropped.
        cyc(); reset_n = 1'b0; #3;
        chk("mrst_resp",  resp_valid, 2'b00);
        chk("mrst_ceb",   sram_ceb, 1'b1);
        chk("mrst_ready", req_ready, 2'b00);
        cyc(); #3;
        chk("mrst_resp2", resp_valid, 2'b00);
        reset_n = 1'b1;
`ifdef SRAM_SP_ARB_INIT_EN
        drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cyc(); #3;
            chk("resweep_a",   sram_a, i);
            chk("resweep_ceb", sram_ceb, 1'b0);
        end
`else
        cyc(); #3;
        chk("rst_ptr", req_ready, 2'b01);
        cyc(); drv(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00); #3;
        chk("rst_ptr_resp", resp_valid, 2'b01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
- Controller that shares one single-port SRAM macro between two requesters (port 0, port 1).
- Macro interface: depth 256, 8-bit data, active-low chip enable and write enable, registered Q valid one cycle after a read. Q is undefined on every cycle not following a read.
- Block arbitrates round-robin, drives the macro pins, and returns read data to the port that issued the read.
- Optional post-reset init sweep zeroes the array before any requester is served.

Parameters:
- DW, 8, data width; must match the macro.
- AW, 8, address width; must match the macro.
- DEPTH, 256, number of words (2**AW).

Ports:
- clock  in  1  clock; also drives the macro CLK.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i is port i.
- req_ready  out  2  per-port request accepted this cycle.
- req_write  in  2  per-port: 1 = write, 0 = read.
- req_addr  in  2*AW  per-port address; port i at bits [i*AW +: AW].
- req_wdata  in  2*DW  per-port write data.
- resp_valid  out  2  per-port read data valid; one-cycle pulse.
- resp_rdata  out  DW  read data, shared by both ports and qualified by resp_valid.
- init_done  out  1  high once the block is serving requests.
- sram_ceb  out  1  macro chip enable, active low.
- sram_web  out  1  macro write enable, active low.
- sram_a  out  AW  macro address.
- sram_d  out  DW  macro write data.
- sram_q  in  DW  macro read data.

Behaviour:
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_rdata = 0.
  - sram_ceb = 1, sram_web = 1, sram_a = 0, sram_d = 0.
  - RR pointer = port 0.
  - init_done = 0 when SRAM_SP_ARB_INIT_EN is defined, 1 otherwise.
- FSM states: INIT, SERVE.
  - Reset enters INIT when the macro is defined, SERVE otherwise.
- INIT:
  - Counter runs 0..DEPTH-1.
  - Each cycle drives sram_ceb = 0, sram_web = 0, sram_a = cnt, sram_d = 0.
  - req_ready = 0.
  - On cnt == DEPTH-1 the next state is SERVE and init_done rises in the same cycle the state changes. The sweep takes exactly DEPTH cycles.
- SERVE:
  - req_ready is combinational: the grant of a one-of-two round-robin over req_valid.
  - With both valid, the port selected by the pointer wins.
  - The pointer moves to the non-granted port after any grant and holds when there is no grant.
  - Handshake is valid & ready. An accepted request drives the macro combinationally in that cycle: sram_ceb = 0, sram_web = ~req_write, sram_a/sram_d from the granted port.
  - With no grant: sram_ceb = 1, sram_web = 1, sram_a/sram_d hold their previous values.
- Read response:
  - A read accepted in cycle N gives resp_valid[i] = 1 in cycle N+1, with resp_rdata = sram_q.
  - There is no backpressure on responses.
  - Writes produce no response.
- Back-to-back: one access per cycle; reads and writes may alternate every cycle with no bubble.
- Same-cycle read/write to the same address from different ports cannot happen; only one is granted.
- Write then read of the same address in the next cycle returns the new data (macro write completes at the edge).
- resp_rdata outside resp_valid is don't-care. Benches must not check it.
- Asynchronous reset mid-operation:
  - All outputs go to their reset values immediately.
  - A read in flight produces no resp_valid.
  - The init sweep restarts from 0.
- Requesters must hold valid/addr/data stable until ready. The block does not check this.

Optional Feature:
- Macro: SRAM_SP_ARB_INIT_EN.
- Defined: INIT sweep as above. req_ready stays 0 for the first DEPTH cycles after reset deassertion.
- Undefined: no INIT state and no counter. init_done is tied 1, SERVE starts on the first cycle after reset, and the array contents are unknown until written.

Decomposition:
- Shared package sram_sp_arb_pkg holds:
  - FSM state enum (ST_INIT, ST_SERVE).
  - Localparam NUM_PORTS = 2.
  - Defaults for DW/AW/DEPTH.
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter.
  - Inputs: valid[1:0], enable, clock, reset_n.
  - Output: one-hot grant[1:0].
  - Holds the pointer register internally.

Test Plan:
- Init sweep (macro defined): release reset, no requests.
  - sram_ceb = 0 and sram_web = 0 for 256 consecutive cycles, sram_a counting 0..255, sram_d = 0.
  - init_done = 1 in cycle 256 and req_ready[0] = 1 when port 0 is valid.
  - A read of address 0x7F then returns 0x00.
- Single-port write/read: port 0 writes 0xA5 to 0x10, then reads 0x10 in the next cycle.
  - resp_valid[0] pulses one cycle after the read grant with resp_rdata = 0xA5.
  - resp_valid[1] stays 0.
- Round-robin contention: both ports hold reads valid for 4 cycles (port 0 to 0x01, port 1 to 0x02).
  - Grants alternate 0,1,0,1.
  - resp_valid alternates with a 1-cycle lag.
  - No port is granted twice in a row.
- Mixed back-to-back: port 1 writes 0x3C to 0xFF, port 0 reads 0xFF in the next cycle.
  - Port 0 receives 0x3C.
  - sram_ceb stays low on both cycles.
- Idle: no valid for 10 cycles.
  - sram_ceb = 1 throughout and resp_valid = 0.
  - RR pointer unchanged.
- Reset mid-read: assert reset_n low in the cycle after a read grant.
  - resp_valid stays 0 and sram_ceb = 1 immediately.
  - With the macro defined, the sweep restarts at sram_a = 0 after release.
